// File: rtl/led_scan_pkg.sv
// Shared types and bus-field positions for the LED scan-bus receiver.
//   ROWS/COLS          : board geometry (16x16)
//   ROW_HI..GRN_HI     : bit positions of the row/red/green fields in the 36-bit bus word
//   pixel_frame_t      : one colour plane, indexed [c][r]
//   state_t            : framing FSM states
//   write_col()        : drops one bus column word into row r of a frame
package led_scan_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int ROW_HI = 35;
    localparam int ROW_LO = 32;
    localparam int RED_HI = 31;
    localparam int GRN_HI = 15;

    typedef logic [15:0][15:0] pixel_frame_t;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // The bus carries column 0 in its MSB, so bit 15-c of the field is pixel c.
    function automatic pixel_frame_t write_col(input pixel_frame_t frame,
                                               input logic [3:0]   row,
                                               input logic [15:0]  bits);
        pixel_frame_t f;
        f = frame;
        for (int c = 0; c < COLS; c++) begin
            f[c][row] = bits[15-c];
        end
        return f;
    endfunction

endpackage

// File: rtl/led_scan_row_settle.sv
// Input conditioning for the scan bus: 2-flop synchroniser followed by a
// stability counter. Emits one capture strobe per settled bus word.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus_in       : raw 36-bit scan bus
//   cap_stb      : 1-cycle capture strobe, word held SETTLE cycles
//   cap_row/red/grn : fields of the word being captured (valid with cap_stb)
//   row_changed  : capture whose row differs from the previously captured row
module led_scan_row_settle
    import led_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [35:0] bus_in,
    output logic        cap_stb,
    output logic [3:0]  cap_row,
    output logic [15:0] cap_red,
    output logic [15:0] cap_grn,
    output logic        row_changed
);

    localparam int CW = $clog2(SETTLE + 1);

    // sync_q[1] is the synchronised word; sync_q[0] is the word it takes next.
    logic [1:0][35:0] sync_q, sync_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       last_row_q, last_row_d;
    logic             stable;

    always_comb begin
        sync_d     = {sync_q[0], bus_in};
        stable     = (sync_q[0] == sync_q[1]);
        cnt_d      = cnt_q;
        last_row_d = last_row_q;

        // Counter parks at SETTLE so a held word is captured only once.
        if (!stable)                  cnt_d = '0;
        else if (cnt_q != CW'(SETTLE)) cnt_d = cnt_q + 1'b1;

        cap_stb     = stable && (cnt_q == CW'(SETTLE - 1));
        cap_row     = sync_q[1][ROW_HI:ROW_LO];
        cap_red     = sync_q[1][RED_HI -: 16];
        cap_grn     = sync_q[1][GRN_HI -: 16];
        row_changed = cap_stb && (cap_row != last_row_q);

        if (cap_stb) last_row_d = cap_row;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            last_row_q <= '0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            last_row_q <= last_row_d;
        end
    end

endmodule

// File: rtl/led_scan_decoder.sv
// Receive side of the 16x16 red/green LED scan bus. Rebuilds both colour
// planes in a shadow buffer and publishes them once per in-order scan.
//   CLK, RST     : clock, synchronous active-low reset
//   GPIO_1       : scan bus {row[3:0], red[15:0], grn[15:0]}
//   RedPixels/GrnPixels : last committed frames, indexed [c][r]
//   FrameValid   : a frame has been committed since reset
//   FrameStrobe  : 1-cycle pulse per commit
//   FrameCount   : commits mod 256
//   SeqError     : sticky out-of-order row flag
//   Stalled      : no row change for 2**TIMEOUT_W cycles
module led_scan_decoder
    import led_scan_pkg::*;
#(
    parameter int SETTLE    = 2,
    parameter int TIMEOUT_W = 20
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [35:0]        GPIO_1,
    output logic [15:0][15:0]  RedPixels,
    output logic [15:0][15:0]  GrnPixels,
    output logic               FrameValid,
    output logic               FrameStrobe,
    output logic [7:0]         FrameCount,
    output logic               SeqError,
    output logic               Stalled
);

    localparam logic [TIMEOUT_W:0] TO_MAX = {1'b1, {TIMEOUT_W{1'b0}}};

    logic        cap_stb, row_changed;
    logic [3:0]  cap_row;
    logic [15:0] cap_red, cap_grn;

    led_scan_row_settle #(.SETTLE(SETTLE)) u_settle (
        .clk         (CLK),
        .rst_n       (RST),
        .bus_in      (GPIO_1),
        .cap_stb     (cap_stb),
        .cap_row     (cap_row),
        .cap_red     (cap_red),
        .cap_grn     (cap_grn),
        .row_changed (row_changed)
    );

    state_t             state_q, state_d;
    logic [3:0]         last_row_q, last_row_d;
    pixel_frame_t       sh_red_q, sh_red_d, sh_grn_q, sh_grn_d;
    pixel_frame_t       red_q, red_d, grn_q, grn_d;
    logic               commit_q, commit_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;
    logic [7:0]         count_q, count_d;
    logic               seqerr_q, seqerr_d;
    logic [TIMEOUT_W:0] to_q, to_d;
    logic [3:0]         exp_row;

    always_comb begin
        state_d    = state_q;
        last_row_d = last_row_q;
        sh_red_d   = sh_red_q;
        sh_grn_d   = sh_grn_q;
        red_d      = red_q;
        grn_d      = grn_q;
        commit_d   = 1'b0;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        count_d    = count_q;
        seqerr_d   = seqerr_q;
        to_d       = to_q;
        exp_row    = last_row_q + 4'd1;

        if (cap_stb) begin
            last_row_d = cap_row;
            unique case (state_q)
                HUNT: begin
                    // Lock only on a genuine 15 -> 0 wrap.
                    if (cap_row == 4'd0 && last_row_q == 4'(ROWS - 1)) begin
                        state_d  = CAPTURE;
                        sh_red_d = write_col(sh_red_q, cap_row, cap_red);
                        sh_grn_d = write_col(sh_grn_q, cap_row, cap_grn);
                    end
                end
                CAPTURE: begin
                    if (!row_changed || cap_row == exp_row) begin
                        sh_red_d = write_col(sh_red_q, cap_row, cap_red);
                        sh_grn_d = write_col(sh_grn_q, cap_row, cap_grn);
                        // Same-row re-captures of row 15 must not re-commit.
                        if (row_changed && cap_row == 4'(ROWS - 1)) commit_d = 1'b1;
                    end else begin
                        seqerr_d = 1'b1;
                        state_d  = HUNT;
                        sh_red_d = '0;
                        sh_grn_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Publish one cycle after the last row landed in the shadow buffer.
        if (commit_q) begin
            red_d    = sh_red_q;
            grn_d    = sh_grn_q;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
            count_d  = count_q + 8'd1;
        end

        if (row_changed)       to_d = '0;
        else if (to_q != TO_MAX) to_d = to_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= HUNT;
            last_row_q <= '0;
            sh_red_q   <= '0;
            sh_grn_q   <= '0;
            red_q      <= '0;
            grn_q      <= '0;
            commit_q   <= 1'b0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            count_q    <= '0;
            seqerr_q   <= 1'b0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_row_q <= last_row_d;
            sh_red_q   <= sh_red_d;
            sh_grn_q   <= sh_grn_d;
            red_q      <= red_d;
            grn_q      <= grn_d;
            commit_q   <= commit_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            count_q    <= count_d;
            seqerr_q   <= seqerr_d;
            to_q       <= to_d;
        end
    end

    assign RedPixels   = red_q;
    assign GrnPixels   = grn_q;
    assign FrameValid  = valid_q;
    assign FrameStrobe = strobe_q;
    assign FrameCount  = count_q;
    assign SeqError    = seqerr_q;
    assign Stalled     = (to_q == TO_MAX);

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder: framing, glitch rejection, stall
// timeout, same-row update, sequence error, reset and frame-count wrap.
module tb_led_scan_decoder;
    import led_scan_pkg::*;

    localparam int SETTLE = 2;
    localparam int TW     = 6;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [35:0]       GPIO_1 = '0;
    logic [15:0][15:0] RedPixels, GrnPixels;
    logic              FrameValid, FrameStrobe, SeqError, Stalled;
    logic [7:0]        FrameCount;

    led_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
        .CLK(CLK), .RST(RST), .GPIO_1(GPIO_1),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels),
        .FrameValid(FrameValid), .FrameStrobe(FrameStrobe),
        .FrameCount(FrameCount), .SeqError(SeqError), .Stalled(Stalled)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int s0, s1;

    always @(negedge CLK) if (FrameStrobe) strobes++;

    pixel_frame_t r1, g1, r2, g2, g3, zf;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] bus_word(input pixel_frame_t r, input pixel_frame_t g, input int row);
        logic [35:0] w;
        logic [3:0]  rr;
        rr = row[3:0];
        w = '0;
        w[35:32] = rr;
        for (int c = 0; c < 16; c++) begin
            w[31-c] = r[c][rr];
            w[15-c] = g[c][rr];
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic scan_row(input pixel_frame_t r, input pixel_frame_t g, input int row, input int dwell);
        GPIO_1 = bus_word(r, g, row);
        tick(dwell);
    endtask

    task automatic scan_pass(input pixel_frame_t r, input pixel_frame_t g, input int first, input int last, input int dwell);
        for (int i = first; i <= last; i++) scan_row(r, g, i, dwell);
    endtask

    initial begin
        zf = '0;
        r1 = '0; g1 = '0; r1[2][3] = 1'b1; g1[1][1] = 1'b1;
        r2 = '0; g2 = '0; r2[5][6] = 1'b1; g2[0][15] = 1'b1;

        // Reset state
        tick(3);
        chk("rst_red", RedPixels, zf);
        chk("rst_grn", GrnPixels, zf);
        chk("rst_valid", FrameValid, 1'b0);
        chk("rst_strobe", FrameStrobe, 1'b0);
        chk("rst_count", FrameCount, 8'd0);
        chk("rst_seqerr", SeqError, 1'b0);
        chk("rst_stalled", Stalled, 1'b0);
        RST = 1'b1;
        s0 = strobes;

        // First pass only arms HUNT; second pass commits
        scan_pass(r1, g1, 0, 15, 8);
        chk("hunt_no_strobe", strobes - s0, 0);
        chk("hunt_valid", FrameValid, 1'b0);
        scan_pass(r1, g1, 0, 15, 8);
        chk("f1_strobes", strobes - s0, 1);
        chk("f1_valid", FrameValid, 1'b1);
        chk("f1_count", FrameCount, 8'd1);
        chk("f1_red23", RedPixels[2][3], 1'b1);
        chk("f1_grn11", GrnPixels[1][1], 1'b1);
        chk("f1_red", RedPixels, r1);
        chk("f1_grn", GrnPixels, g1);
        chk("f1_seqerr", SeqError, 1'b0);

        // Glitch: a row-3 word for SETTLE-1 cycles, then row 15 restored
        GPIO_1 = bus_word(r1, g1, 3);
        tick(SETTLE - 1);
        GPIO_1 = bus_word(r1, g1, 15);
        tick(10);
        chk("glitch_seqerr", SeqError, 1'b0);
        chk("glitch_strobes", strobes - s0, 1);
        chk("glitch_red", RedPixels, r1);

        // Stall mid-frame on row 7: captured 4 cycles after the bus change
        scan_pass(r1, g1, 0, 6, 8);
        GPIO_1 = bus_word(r1, g1, 7);
        tick(67);
        chk("stall_before", Stalled, 1'b0);
        tick(1);
        chk("stall_at_64", Stalled, 1'b1);
        tick(4);
        chk("stall_sat", Stalled, 1'b1);
        chk("stall_count", FrameCount, 8'd1);
        scan_row(r1, g1, 8, 8);
        chk("stall_clear", Stalled, 1'b0);
        scan_pass(r1, g1, 9, 15, 8);
        chk("f2_count", FrameCount, 8'd2);
        chk("f2_seqerr", SeqError, 1'b0);
        chk("f2_strobes", strobes - s0, 2);

        // Same-row data change while row 9 dwells
        g3 = g1;
        scan_pass(r1, g1, 0, 9, 8);
        g3[4][9] = 1'b1;
        scan_row(r1, g3, 9, 8);
        chk("tog_held_grn", GrnPixels, g1);
        chk("tog_seqerr", SeqError, 1'b0);
        scan_pass(r1, g3, 10, 15, 8);
        chk("f3_grn49", GrnPixels[4][9], 1'b1);
        chk("f3_grn", GrnPixels, g3);
        chk("f3_count", FrameCount, 8'd3);
        chk("f3_seqerr", SeqError, 1'b0);

        // Skip row 5 while in CAPTURE
        scan_pass(r2, g2, 0, 4, 8);
        scan_row(r2, g2, 6, 8);
        chk("skip_seqerr", SeqError, 1'b1);
        chk("skip_red_held", RedPixels, r1);
        chk("skip_grn_held", GrnPixels, g3);
        scan_pass(r2, g2, 7, 15, 8);
        chk("skip_hunt_count", FrameCount, 8'd3);
        chk("skip_hunt_strobes", strobes - s0, 3);
        scan_pass(r2, g2, 0, 15, 8);
        chk("f4_count", FrameCount, 8'd4);
        chk("f4_red", RedPixels, r2);
        chk("f4_grn", GrnPixels, g2);
        chk("f4_seqerr_sticky", SeqError, 1'b1);

        // Reset asserted mid-frame at row 7
        scan_pass(r2, g2, 0, 7, 8);
        RST = 1'b0;
        tick(1);
        chk("mrst_red", RedPixels, zf);
        chk("mrst_grn", GrnPixels, zf);
        chk("mrst_valid", FrameValid, 1'b0);
        chk("mrst_count", FrameCount, 8'd0);
        chk("mrst_seqerr", SeqError, 1'b0);
        chk("mrst_stalled", Stalled, 1'b0);
        RST = 1'b1;

        // 257 committed frames wrap the counter to 1
        s1 = strobes;
        scan_pass(r2, g2, 8, 15, 6);
        for (int f = 0; f < 257; f++) scan_pass(r2, g2, 0, 15, 6);
        chk("wrap_count", FrameCount, 8'd1);
        chk("wrap_strobes", strobes - s1, 257);
        chk("wrap_valid", FrameValid, 1'b1);
        chk("wrap_red", RedPixels, r2);
        chk("wrap_seqerr", SeqError, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
